// File: rtl/xulie_pkg.sv
// Shared types and defaults for the xulie serial transmitter and its pattern recogniser.
package xulie_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   localparam int unsigned WidthDefault = 16;
   localparam logic [3:0] PatternDefault = 4'b0110;
   localparam int unsigned MatchCntW = 5;
   localparam logic [MatchCntW-1:0] MatchCntMax = '1;

endpackage

// File: rtl/xulie_match_cnt.sv
// Moore recogniser counting overlapping 4-bit PATTERN occurrences in a qualified bit stream.
module xulie_match_cnt
   import xulie_pkg::*;
#(
   parameter logic [3:0] PATTERN = PatternDefault
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 bit_valid,
   input  logic                 bit_in,
   output logic [MatchCntW-1:0] match_cnt
);

   logic [2:0]           hist_q, hist_d;
   logic [1:0]           fill_q, fill_d;
   logic [MatchCntW-1:0] cnt_q, cnt_d;
   logic                 hit;

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      // fill_q gates matching so stale or cleared history bits never complete a pattern
      hit    = (fill_q == 2'd3) && ({hist_q, bit_in} == PATTERN);
      if (clear) begin
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
      end else if (bit_valid) begin
         hist_d = {hist_q[1:0], bit_in};
         if (fill_q != 2'd3) begin
            fill_d = fill_q + 2'd1;
         end
         if (hit && (cnt_q != MatchCntMax)) begin
            cnt_d = cnt_q + MatchCntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;

endmodule

// File: rtl/xulie_tx_serial.sv
// MSB-first serial frame transmitter with IDLE/SHIFT/DONE control and a per-frame
// count of overlapping PATTERN occurrences in the transmitted bits.
module xulie_tx_serial
   import xulie_pkg::*;
#(
   parameter int unsigned WIDTH   = WidthDefault,
   parameter logic [3:0]  PATTERN = PatternDefault
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [WIDTH-1:0]     data_in,
   input  logic [4:0]           len,
   output logic                 Dout,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [MatchCntW-1:0] match_cnt
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [4:0]       eff_len;
   logic             accept;

   always_comb begin
      eff_len = (len == 5'd0) ? 5'd16 : len;
      if (32'(eff_len) > WIDTH) begin
         eff_len = 5'(WIDTH);
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               accept  = 1'b1;
               shift_d = data_in;
               cnt_d   = eff_len;
               state_d = StShift;
            end
         end
         StShift: begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - 5'd1;
            // Counter runs len..1, so it never wraps through zero
            if (cnt_q == 5'd1) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready = (state_q == StIdle);
   assign busy  = (state_q == StShift);
   assign done  = (state_q == StDone);
   assign Dout  = busy & shift_q[WIDTH-1];

   xulie_match_cnt #(
      .PATTERN (PATTERN)
   ) u_match_cnt (
      .clk       (clk),
      .reset     (reset),
      .clear     (accept),
      .bit_valid (busy),
      .bit_in    (Dout),
      .match_cnt (match_cnt)
   );

endmodule

// File: tb/tb_xulie_tx_serial.sv
// Directed bench for xulie_tx_serial: framing, pattern counts, back-to-back loads and reset abort.
module tb_xulie_tx_serial;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] data_in;
   logic [4:0]  len;
   logic        Dout;
   logic        ready;
   logic        busy;
   logic        done;
   logic [4:0]  match_cnt;

   int n_pass;
   int n_total;

   xulie_tx_serial dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .data_in   (data_in),
      .len       (len),
      .Dout      (Dout),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .match_cnt (match_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_idle(input string tag, input logic [4:0] exp_match);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_dout"}, Dout, 0);
      check({tag, "_match"}, match_cnt, exp_match);
   endtask

   // bits holds the expected serial stream left-justified, first bit in bits[15]
   task automatic run_frame(input string tag, input logic [15:0] data, input logic [4:0] l,
                            input logic [15:0] bits, input int n, input logic [4:0] m);
      data_in = data;
      len     = l;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      for (int i = 0; i < n; i++) begin
         check({tag, "_dout"}, Dout, bits[15-i]);
         check({tag, "_busy"}, busy, 1);
         tick();
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_done_dout"}, Dout, 0);
      check({tag, "_done_ready"}, ready, 0);
      check({tag, "_match"}, match_cnt, m);
      tick();
      check_idle({tag, "_after"}, m);
   endtask

   initial begin
      logic [15:0] bits;
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b0;
      load    = 1'b0;
      data_in = '0;
      len     = '0;

      // Reset state, including edges with load asserted while reset is held
      #2;
      check_idle("rst", 0);
      load = 1'b1;
      tick();
      tick();
      check_idle("rst_hold", 0);
      load = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Scenario 1: len=0 means 16 bits, load taken on first edge after release
      run_frame("s1", 16'h2DB2, 5'd0, 16'b0010110110110010, 16, 5'd3);

      // Scenario 2: short frame
      run_frame("s2", 16'h6000, 5'd4, 16'b0110000000000000, 4, 5'd1);

      // Minimum length frame
      run_frame("len1", 16'h8000, 5'd1, 16'b1000000000000000, 1, 5'd0);

      // Scenario 3: maximal overlapping stream
      run_frame("s3", 16'h6DB6, 5'd16, 16'b0110110110110110, 16, 5'd5);

      // Scenario 4: load held high -> back-to-back frames with a 2-cycle gap
      data_in = 16'h6000;
      len     = 5'd4;
      load    = 1'b1;
      bits    = 16'b0110000000000000;
      for (int f = 0; f < 3; f++) begin
         tick();
         check("s4_cleared", match_cnt, 0);
         for (int i = 0; i < 4; i++) begin
            check("s4_dout", Dout, bits[15-i]);
            check("s4_busy", busy, 1);
            tick();
         end
         check("s4_done", done, 1);
         check("s4_done_busy", busy, 0);
         check("s4_match", match_cnt, 1);
         tick();
         check("s4_idle_ready", ready, 1);
         check("s4_idle_busy", busy, 0);
         check("s4_idle_match", match_cnt, 1);
      end
      load = 1'b0;
      tick();
      check_idle("s4_end", 1);

      // Scenario 5: reset mid-frame aborts immediately, no done pulse
      data_in = 16'h6DB6;
      len     = 5'd0;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      bits    = 16'b0110110110110110;
      for (int i = 0; i < 4; i++) begin
         check("s5_dout", Dout, bits[15-i]);
         tick();
      end
      check("s5_pre_dout", Dout, 1);
      check("s5_pre_match", match_cnt, 1);
      check("s5_pre_busy", busy, 1);
      #2;
      reset = 1'b0;
      #1;
      check_idle("s5_async", 0);
      tick();
      check_idle("s5_held", 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_idle("s5_release", 0);
      tick();
      check("s5_no_done", done, 0);
      run_frame("s5_new", 16'h2DB2, 5'd0, 16'b0010110110110010, 16, 5'd3);

      // Scenario 6: data_in and load wiggled during SHIFT
      data_in = 16'h6DB6;
      len     = 5'd0;
      load    = 1'b1;
      tick();
      bits    = 16'b0110110110110110;
      for (int i = 0; i < 16; i++) begin
         check("s6_dout", Dout, bits[15-i]);
         check("s6_busy", busy, 1);
         data_in = ~data_in;
         load    = (i == 15) ? 1'b1 : ((i % 2) == 0);
         tick();
      end
      check("s6_done", done, 1);
      check("s6_match", match_cnt, 5);
      tick();
      // load was high at the DONE edge but must not start a frame
      check_idle("s6_idle", 5);
      load = 1'b0;
      tick();
      check_idle("s6_stay", 5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/xulie_tx_serial.md
XULIE_TX_SERIAL -- requirements
Module: xulie_tx_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the maximum frame length in bits.
REQ-002 The block SHALL have parameter PATTERN, default 4'b0110, giving the 4-bit sequence counted in the transmitted stream.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port load, input, 1 bit: frame request, sampled on a rising edge while ready=1.
REQ-006 The block SHALL have port data_in, input, WIDTH bits: frame bits, transmitted MSB first from data_in[WIDTH-1].
REQ-007 The block SHALL have port len, input, 5 bits: number of bits to send, 1..16; the value 0 means 16.
REQ-008 The block SHALL have port Dout, output, 1 bit: serial data.
REQ-009 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-010 The block SHALL have port busy, output, 1 bit: high in SHIFT.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-012 The block SHALL have port match_cnt, output, 5 bits: overlapping PATTERN occurrences counted in the current or last frame.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with load=1 at a rising edge, the block SHALL capture data_in and len, clear match_cnt and the pattern history, and enter SHIFT.
REQ-015 load SHALL be ignored while not in IDLE.
REQ-016 In SHIFT, Dout SHALL present one bit per cycle: the first bit (data_in[WIDTH-1]) in the first cycle after the accepting edge, then descending bits.
REQ-017 The block SHALL stay in SHIFT for exactly len cycles (16 when len=0), then enter DONE.
REQ-018 Bit counter wrap-around SHALL NOT occur: the counter is loaded with the effective length and decrements to 1, then the FSM transitions.
REQ-019 DONE SHALL last one cycle with done=1 and Dout=0, then return to IDLE.
REQ-020 The first new load is accepted at the first IDLE edge, giving a minimum frame-to-frame gap of 2 cycles (DONE plus IDLE).
REQ-021 Outside SHIFT, Dout SHALL be 0.
REQ-022 The pattern counter SHALL be a Moore recogniser fed by the bits present on Dout during SHIFT.
- Overlapping matches count: 0110110 counts 2.
- Bits from a previous frame do not contribute.
REQ-023 match_cnt SHALL update on the edge that ends each bit cycle, so its final value is valid during DONE.
REQ-024 match_cnt SHALL hold its final value until the next accepted load.
REQ-025 match_cnt SHALL saturate at 31.
REQ-026 load=1 in the same cycle the block enters IDLE from DONE SHALL NOT be accepted; acceptance requires ready=1 at the sampling edge.

Reset
REQ-027 While reset=0, regardless of clk, outputs SHALL be:
- Dout=0, busy=0, done=0, ready=1, match_cnt=0
- FSM in IDLE
- bit counter and pattern history cleared
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately.
- No done pulse is produced.
- After reset release, the block waits in IDLE for a new load.
REQ-029 The first rising edge after reset deasserts MAY accept a load.

Structure
REQ-030 The shared package xulie_pkg SHALL hold:
- FSM state encoding type
- WIDTH default
- PATTERN default 4'b0110
- match_cnt width constant (5)
REQ-031 The pattern recogniser SHALL be a separate sub-module, xulie_match_cnt.
- Inputs: clk, reset, clear, bit_valid, bit_in
- Output: match_cnt
- Reusable to check the receive side.
REQ-032 The top level SHALL contain the FSM, the shift register and the bit counter.

Verification
REQ-033 Scenario 1: data_in=16'h2DB2, len=0, pulse load.
- Dout = 0,0,1,0,1,1,0,1,1,0,1,1,0,0,1,0 over 16 cycles.
- done on cycle 17.
- match_cnt=3.
REQ-034 Scenario 2: data_in=16'h6000, len=4.
- Dout=0,1,1,0.
- busy for 4 cycles.
- match_cnt=1.
- ready returns 2 cycles after the last bit.
REQ-035 Scenario 3: data_in=16'h6DB6, len=16.
- Overlapping stream 0110110110110110.
- match_cnt=5.
REQ-036 Scenario 4: load held high continuously with data_in=16'h6000, len=4.
- Back-to-back frames with exactly 2 non-SHIFT cycles between them.
- match_cnt cleared to 0 then reaches 1 each frame.
REQ-037 Scenario 5: reset pulsed low in cycle 5 of a 16-bit frame.
- All outputs return to reset values asynchronously.
- No done pulse.
- The next load transmits a full new frame.
REQ-038 Scenario 6: data_in and load toggled during SHIFT.
- Transmitted bits are unaffected.
- No second frame starts until ready=1.
